// File: rtl/jpeg_mcu_sched.sv
// ---------------------------------------------------------------------------
// jpeg_mcu_sched
//
// Frame-level scheduler sitting between the upstream MCU writer, a two-bank
// 16x16 MCU buffer and the YCbCr->RGB converter. It counts MCUs across the
// image, tracks which bank holds a complete MCU, hands free banks to the
// writer and starts the converter on each full bank in raster order.
//
// Ports
//   i_clk, i_rst        clock (posedge) and synchronous active-high reset.
//                       The converter shares i_rst so its bank pointer also
//                       restarts at 0 together with ours.
//   i_Start             start-of-frame pulse; latches image size in IDLE
//   i_ImageWidth/Height image size in pixels
//   i_WrDone            writer finished filling bank o_WrBank (1 cycle)
//   o_WrBank            bank the writer must fill next
//   o_WrReady           o_WrBank is free and the frame still needs MCUs
//   i_ConvIdle          converter idle
//   i_ConvBank          converter bank pointer; toggles when a bank is consumed
//   o_ConvEnable        converter start pulse (1 cycle)
//   o_ConvBlockX/Y      MCU coordinates of the bank being started
//   o_Busy              frame in progress
//   o_FrameDone         1-cycle pulse after the last MCU has been consumed
//   o_ErrOverflow       sticky: i_WrDone seen while o_WrReady was low
// ---------------------------------------------------------------------------
module jpeg_mcu_sched #(
    parameter int BW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_Start,
    input  logic [15:0]   i_ImageWidth,
    input  logic [15:0]   i_ImageHeight,
    input  logic          i_WrDone,
    output logic          o_WrBank,
    output logic          o_WrReady,
    input  logic          i_ConvIdle,
    input  logic          i_ConvBank,
    output logic          o_ConvEnable,
    output logic [BW-1:0] o_ConvBlockX,
    output logic [BW-1:0] o_ConvBlockY,
    output logic          o_Busy,
    output logic          o_FrameDone,
    output logic          o_ErrOverflow
);

    localparam int            PW     = 2 * BW;
    localparam logic [BW-1:0] ONE_BW = BW'(1);
    localparam logic [PW-1:0] ONE_PW = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_mcu_w;
    logic [BW-1:0] r_mcu_h;
    logic [PW-1:0] r_mcu_total;
    logic [PW-1:0] r_wr_cnt;
    logic [BW-1:0] r_rd_x;
    logic [BW-1:0] r_rd_y;
    logic [BW-1:0] r_blk_x;
    logic [BW-1:0] r_blk_y;
    logic [1:0]    r_full;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic          r_busy;
    logic          r_conv_en;
    logic          r_frame_done;
    logic          r_err_ovf;

    logic [16:0]   w_w_round;
    logic [16:0]   w_h_round;
    logic [BW-1:0] w_mcu_w;
    logic [BW-1:0] w_mcu_h;
    logic          w_start_ok;
    logic          w_wr_ready;
    logic          w_wr_acc;
    logic          w_release;
    logic          w_x_last;
    logic          w_y_last;
    logic [1:0]    w_full_nxt;

    // Round pixel size up to whole 16-pixel MCUs; one extra bit keeps the
    // +15 from wrapping before the result is truncated to BW bits.
    assign w_w_round = {1'b0, i_ImageWidth}  + 17'd15;
    assign w_h_round = {1'b0, i_ImageHeight} + 17'd15;
    assign w_mcu_w   = BW'(w_w_round >> 4);
    assign w_mcu_h   = BW'(w_h_round >> 4);

    assign w_start_ok = (r_state == S_IDLE) && i_Start &&
                        (i_ImageWidth != 16'd0) && (i_ImageHeight != 16'd0);

    assign w_wr_ready = r_busy && !r_full[r_wr_bank] && (r_wr_cnt < r_mcu_total);
    assign w_wr_acc   = i_WrDone && w_wr_ready;

    // The converter flips its bank pointer once it has consumed our bank.
    assign w_release  = (r_state == S_RUN) && (i_ConvBank != r_rd_bank);

    assign w_x_last   = (r_rd_x == r_mcu_w - ONE_BW);
    assign w_y_last   = (r_rd_y == r_mcu_h - ONE_BW);

    // Writer fill and converter release may land in the same cycle on
    // different banks; both must survive. The same bank cannot be hit by
    // both, because the writer is held off while that bank is full.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_acc)  w_full_nxt[r_wr_bank] = 1'b1;
        if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_mcu_w      <= '0;
            r_mcu_h      <= '0;
            r_mcu_total  <= '0;
            r_wr_cnt     <= '0;
            r_rd_x       <= '0;
            r_rd_y       <= '0;
            r_blk_x      <= '0;
            r_blk_y      <= '0;
            r_full       <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_busy       <= 1'b0;
            r_conv_en    <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_ovf    <= 1'b0;
        end else begin
            r_full       <= w_full_nxt;
            r_conv_en    <= 1'b0;
            r_frame_done <= 1'b0;

            // Write side
            if (w_wr_acc) begin
                r_wr_bank <= ~r_wr_bank;
                r_wr_cnt  <= r_wr_cnt + ONE_PW;
            end else if (i_WrDone) begin
                r_err_ovf <= 1'b1;
            end

            // Read side / converter sequencing
            case (r_state)
                S_IDLE: begin
                    // Bank pointers are not reset here: they stay aligned
                    // with the converter's pointer across frames.
                    if (w_start_ok) begin
                        r_mcu_w     <= w_mcu_w;
                        r_mcu_h     <= w_mcu_h;
                        r_mcu_total <= PW'(w_mcu_w) * PW'(w_mcu_h);
                        r_wr_cnt    <= '0;
                        r_rd_x      <= '0;
                        r_rd_y      <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_full[r_rd_bank] && i_ConvIdle) begin
                        r_conv_en <= 1'b1;
                        r_blk_x   <= r_rd_x;
                        r_blk_y   <= r_rd_y;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_release) begin
                        r_rd_bank <= ~r_rd_bank;
                        if (w_x_last && w_y_last) begin
                            r_rd_x       <= '0;
                            r_rd_y       <= '0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            if (w_x_last) begin
                                r_rd_x <= '0;
                                r_rd_y <= r_rd_y + ONE_BW;
                            end else begin
                                r_rd_x <= r_rd_x + ONE_BW;
                            end
                            r_state <= S_WAIT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_WrBank      = r_wr_bank;
    assign o_WrReady     = w_wr_ready;
    assign o_ConvEnable  = r_conv_en;
    assign o_ConvBlockX  = r_blk_x;
    assign o_ConvBlockY  = r_blk_y;
    assign o_Busy        = r_busy;
    assign o_FrameDone   = r_frame_done;
    assign o_ErrOverflow = r_err_ovf;

endmodule
